sysid_check_sequencer: RTL

//  Sequencer that owns the system-ID control slave (32-bit readdata, 1-bit address).
//  It reads word 0 (system ID) then word 1 (build timestamp), and compares both against build-time constants.
//  It reports match/mismatch to boot/supervisor logic.
//  It runs once automatically out of reset and again on each start pulse; a saturating counter tracks failed checks.

---
 rtl/sysid_check_sequencer_if.sv | 19 +
 rtl/sysid_check_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sysid_check_sequencer_if.sv
// Read-only bus between the sequencer and the
// system-ID slave (one address bit, 32-bit data).
interface sysid_check_sequencer_if;
  logic        address;
  logic        read;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    output readdata
  );
endinterface

// File: rtl/sysid_check_sequencer.sv
// Reads sysid word 0 and word 1, checks both
// against build constants and counts failed checks.
module sysid_check_sequencer #(
  parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS  = 32'h6685_A631,
  parameter int unsigned READ_LATENCY = 0,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  sysid_check_sequencer_if.master sysid,
  output logic        busy,
  output logic        done,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [7:0]  fail_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_WAIT_ID,
    S_RD_TS,
    S_WAIT_TS,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int unsigned LM1 =
    (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
  localparam logic [2:0] LAST = LM1[2:0];
  localparam bit ZERO_LAT = (READ_LATENCY == 0);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_cnt;
  logic        r_auto;
  logic [31:0] r_id;
  logic [31:0] r_ts;
  logic        r_id_ok;
  logic        r_ts_ok;
  logic [7:0]  r_fail;

  logic        w_cap_id;
  logic        w_cap_ts;
  logic        w_clr_auto;
  logic        w_cnt_clr;
  logic        w_cnt_inc;
  logic        w_id_match;
  logic        w_ts_match;

  assign w_id_match = (r_id == EXPECTED_ID);
  assign w_ts_match = (r_ts == EXPECTED_TS);

  always_comb begin
    w_next     = r_state;
    w_cap_id   = 1'b0;
    w_cap_ts   = 1'b0;
    w_clr_auto = 1'b0;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    sysid.read    = 1'b0;
    sysid.address = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start || r_auto) begin
          w_next     = S_RD_ID;
          w_clr_auto = 1'b1;
        end
      end
      S_RD_ID: begin
        sysid.read = 1'b1;
        w_cnt_clr  = 1'b1;
        if (ZERO_LAT) begin
          w_cap_id = 1'b1;
          w_next   = S_RD_TS;
        end else begin
          w_next = S_WAIT_ID;
        end
      end
      S_WAIT_ID: begin
        w_cnt_inc = 1'b1;
        if (r_cnt == LAST) begin
          w_cap_id = 1'b1;
          w_next   = S_RD_TS;
        end
      end
      S_RD_TS: begin
        sysid.read    = 1'b1;
        sysid.address = 1'b1;
        w_cnt_clr     = 1'b1;
        if (ZERO_LAT) begin
          w_cap_ts = 1'b1;
          w_next   = S_CHECK;
        end else begin
          w_next = S_WAIT_TS;
        end
      end
      S_WAIT_TS: begin
        sysid.address = 1'b1;
        w_cnt_inc     = 1'b1;
        if (r_cnt == LAST) begin
          w_cap_ts = 1'b1;
          w_next   = S_CHECK;
        end
      end
      S_CHECK: w_next = S_DONE;
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_auto  <= AUTO_START;
      r_id    <= 32'd0;
      r_ts    <= 32'd0;
      r_id_ok <= 1'b0;
      r_ts_ok <= 1'b0;
      r_fail  <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_clr_auto) r_auto <= 1'b0;
      if (w_cnt_clr) r_cnt <= 3'd0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 3'd1;
      if (w_cap_id) r_id <= sysid.readdata;
      if (w_cap_ts) r_ts <= sysid.readdata;
      if (r_state == S_CHECK) begin
        r_id_ok <= w_id_match;
        r_ts_ok <= w_ts_match;
        // saturate rather than wrap so a long failure history stays visible
        if (!(w_id_match && w_ts_match) && r_fail != 8'hFF)
          r_fail <= r_fail + 8'd1;
      end
    end
  end

  assign id_value   = r_id;
  assign ts_value   = r_ts;
  assign id_ok      = r_id_ok;
  assign ts_ok      = r_ts_ok;
  assign fail_count = r_fail;

endmodule
